// File: rtl/tagged_sum_pkg.sv
// Shared definitions for the tagged-sum word format {TAG, sum}, used by both
// the producer and the unpacker.
package tagged_sum_pkg;

    localparam int unsigned SUM_W = 16;
    localparam logic [SUM_W-1:0] TAG_MARKER = 16'hFFFF;

    typedef struct packed {
        logic [SUM_W-1:0] tag;
        logic [SUM_W-1:0] sum;
    } tagged_word_t;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with extra-MSB wrap pointers; head_o is the registered
// entry at the read pointer (first-word-fall-through).
module sync_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] data_i,
    output logic             full_o,
    output logic             empty_o,
    output logic [WIDTH-1:0] head_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push, do_pop;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign head_o  = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage needs no reset: the pointers alone decide what is visible.
    always_ff @(posedge clk) begin
        if (!rst && do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= data_i;
        end
    end

endmodule

// File: rtl/tagged_sum_unpacker.sv
// Receive side of the tagged-sum format: checks the tag, buffers good words,
// and delivers the sum with the recovered operand b = sum - a.
module tagged_sum_unpacker
    import tagged_sum_pkg::*;
#(
    parameter int unsigned W     = SUM_W,
    parameter logic [W-1:0] TAG  = TAG_MARKER,
    parameter int unsigned DEPTH = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [2*W-1:0] in_word,
    input  logic [W-1:0]   in_a,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [W-1:0]   out_sum,
    output logic [W-1:0]   out_b,
    output logic           err_pulse,
    output logic [W-1:0]   err_count
);

    logic           alive_q;
    logic           accept, tag_ok, push, reject, pop;
    logic           full, empty;
    logic [2*W-1:0] fifo_data, head;
    logic [W-1:0]   hold_sum_q, hold_sum_d;
    logic [W-1:0]   hold_b_q, hold_b_d;
    logic [W-1:0]   err_count_q, err_count_d;
    logic           err_pulse_q;

    // in_ready is a function of registered state only.
    assign in_ready  = alive_q && !full;
    assign accept    = in_valid && in_ready;
    assign tag_ok    = (in_word[2*W-1:W] == TAG);
    assign push      = accept && tag_ok;
    assign reject    = accept && !tag_ok;
    assign fifo_data = {in_word[W-1:0], in_word[W-1:0] - in_a};

    assign out_valid = !empty;
    assign pop       = out_valid && out_ready;
    assign out_sum   = empty ? hold_sum_q : head[2*W-1:W];
    assign out_b     = empty ? hold_b_q : head[W-1:0];
    assign err_pulse = err_pulse_q;
    assign err_count = err_count_q;

    sync_fifo #(
        .WIDTH (2 * W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .pop_i   (pop),
        .data_i  (fifo_data),
        .full_o  (full),
        .empty_o (empty),
        .head_o  (head)
    );

    // The popped head becomes the value shown once the FIFO drains.
    always_comb begin
        hold_sum_d  = hold_sum_q;
        hold_b_d    = hold_b_q;
        err_count_d = err_count_q;
        if (pop) begin
            hold_sum_d = head[2*W-1:W];
            hold_b_d   = head[W-1:0];
        end
        if (reject && (err_count_q != {W{1'b1}})) begin
            err_count_d = err_count_q + W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            alive_q     <= 1'b0;
            hold_sum_q  <= '0;
            hold_b_q    <= '0;
            err_count_q <= '0;
            err_pulse_q <= 1'b0;
        end else begin
            alive_q     <= 1'b1;
            hold_sum_q  <= hold_sum_d;
            hold_b_q    <= hold_b_d;
            err_count_q <= err_count_d;
            err_pulse_q <= reject;
        end
    end

endmodule
